mem_port_arbiter: RTL and testbench

- Shares the single memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Allows one outstanding transaction at a time.
- Arbitrates by round-robin or fixed LSU priority, and latches the winning request.
- Sequences the memory handshake and routes the response back to its owner. A response-timeout counter flags a hung memory.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU (read/write), one transaction in flight.
// Latency: grant at cycle 0, mem_req_valid at cycle 1, owner resp_valid one cycle after mem_resp_valid.
// Backpressure: req_ready is offered only in IDLE; mem_req_valid holds with stable fields until mem_req_ready.
module mem_port_arbiter #(
  parameter bit          LSU_PRIO = 1'b0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_lsu_q, last_lsu_d;    // 1 = LSU was granted most recently
  logic        owner_lsu_q, owner_lsu_d;  // 1 = in-flight transaction belongs to LSU
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        ifu_resp_valid_q, ifu_resp_valid_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic        lsu_resp_valid_q, lsu_resp_valid_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        gnt_ifu, gnt_lsu;

  // Arbitration: a winner exists only in IDLE; on a tie round-robin favours whoever did not go last
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (state_q == S_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (LSU_PRIO || !last_lsu_q) gnt_lsu = 1'b1;
        else                         gnt_ifu = 1'b1;
      end else begin
        gnt_ifu = ifu_req_valid;
        gnt_lsu = lsu_req_valid;
      end
    end
  end

  // Next-state: latch winner, run the memory handshake, deliver response or timeout error
  always_comb begin
    state_d          = state_q;
    last_lsu_d       = last_lsu_q;
    owner_lsu_d      = owner_lsu_q;
    cnt_d            = cnt_q;
    cnt_inc          = cnt_q + 8'd1;
    mem_req_valid_d  = mem_req_valid_q;
    mem_addr_d       = mem_addr_q;
    mem_wen_d        = mem_wen_q;
    mem_wdata_d      = mem_wdata_q;
    mem_wmask_d      = mem_wmask_q;
    ifu_resp_valid_d = 1'b0;
    ifu_rdata_d      = ifu_rdata_q;
    lsu_resp_valid_d = 1'b0;
    lsu_rdata_d      = lsu_rdata_q;
    bus_err_d        = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_ifu || gnt_lsu) begin
          owner_lsu_d     = gnt_lsu;
          last_lsu_d      = gnt_lsu;
          mem_addr_d      = gnt_lsu ? lsu_addr : ifu_addr;
          mem_wen_d       = gnt_lsu & lsu_wen;
          mem_wdata_d     = gnt_lsu ? lsu_wdata : 32'h0;
          mem_wmask_d     = gnt_lsu ? lsu_wmask : 4'h0;
          mem_req_valid_d = 1'b1;
          state_d         = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = 8'd0;
          state_d         = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          if (owner_lsu_q) begin
            lsu_resp_valid_d = 1'b1;
            lsu_rdata_d      = mem_rdata;
          end else begin
            ifu_resp_valid_d = 1'b1;
            ifu_rdata_d      = mem_rdata;
          end
          state_d = S_IDLE;
        end else if (cnt_inc == TIMEOUT_W) begin
          // Memory is presumed hung: complete with zero data and raise the sticky error
          if (owner_lsu_q) begin
            lsu_resp_valid_d = 1'b1;
            lsu_rdata_d      = 32'h0;
          end else begin
            ifu_resp_valid_d = 1'b1;
            ifu_rdata_d      = 32'h0;
          end
          bus_err_d = 1'b1;
          cnt_d     = cnt_inc;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      last_lsu_q       <= 1'b1;
      owner_lsu_q      <= 1'b0;
      cnt_q            <= 8'd0;
      mem_req_valid_q  <= 1'b0;
      mem_addr_q       <= 32'h0;
      mem_wen_q        <= 1'b0;
      mem_wdata_q      <= 32'h0;
      mem_wmask_q      <= 4'h0;
      ifu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= 32'h0;
      lsu_resp_valid_q <= 1'b0;
      lsu_rdata_q      <= 32'h0;
      bus_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_lsu_q       <= last_lsu_d;
      owner_lsu_q      <= owner_lsu_d;
      cnt_q            <= cnt_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_addr_q       <= mem_addr_d;
      mem_wen_q        <= mem_wen_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_wmask_q      <= mem_wmask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_rdata_q      <= ifu_rdata_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_rdata_q      <= lsu_rdata_d;
      bus_err_q        <= bus_err_d;
    end
  end

  assign ifu_req_ready  = gnt_ifu;
  assign lsu_req_ready  = gnt_lsu;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wen        = mem_wen_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level driver, memory responder, scoreboard monitors.
// Expected grants, memory fields, response data/cycle and bus_err come from a queue-based model.
// A second instance with fixed LSU priority is flooded with requests to confirm the IFU never wins.
module tb_mem_port_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  mem_port_arbiter #(.LSU_PRIO(1'b0), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  // Fixed-priority instance: both requesters always valid, memory always ready/responding
  logic        p_ifu_v = 1'b1, p_lsu_v = 1'b1, p_one = 1'b1;
  logic        p_ifu_req_ready, p_ifu_resp_valid, p_lsu_req_ready, p_lsu_resp_valid;
  logic        p_mem_req_valid, p_mem_wen, p_bus_err;
  logic [31:0] p_ifu_rdata, p_lsu_rdata, p_mem_addr, p_mem_wdata;
  logic [3:0]  p_mem_wmask;

  mem_port_arbiter #(.LSU_PRIO(1'b1), .TIMEOUT(255)) u_prio (
    .clk(clk), .rst(rst),
    .ifu_req_valid(p_ifu_v), .ifu_req_ready(p_ifu_req_ready), .ifu_addr(32'h1000),
    .ifu_resp_valid(p_ifu_resp_valid), .ifu_rdata(p_ifu_rdata),
    .lsu_req_valid(p_lsu_v), .lsu_req_ready(p_lsu_req_ready), .lsu_addr(32'h2000),
    .lsu_wen(1'b0), .lsu_wdata(32'h0), .lsu_wmask(4'h0),
    .lsu_resp_valid(p_lsu_resp_valid), .lsu_rdata(p_lsu_rdata),
    .mem_req_valid(p_mem_req_valid), .mem_req_ready(p_one), .mem_addr(p_mem_addr),
    .mem_wen(p_mem_wen), .mem_wdata(p_mem_wdata), .mem_wmask(p_mem_wmask),
    .mem_resp_valid(p_one), .mem_rdata(32'h1234_5678), .bus_err(p_bus_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask; } req_t;
  typedef struct { logic lsu; logic [31:0] rdata; logic tmo; } resp_t;

  req_t  exp_req[$];
  resp_t exp_resp[$];
  int    exp_lat[$];

  // Reference model state
  logic        last_lsu = 1'b1;
  logic        exp_bus_err = 1'b0;
  logic [31:0] exp_ifu_rd = 32'h0, exp_lsu_rd = 32'h0;

  // Memory responder configuration for the current transaction
  int rdly = 0, rsdly = 0;
  bit nresp = 1'b0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h8010_0073;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Memory responder: ready after rdly REQ cycles, response rsdly cycles after the handshake
  initial begin
    logic [31:0] a;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req_valid === 1'b1 && !rst) begin
        a = mem_addr;
        repeat (rdly) @(negedge clk);
        mem_req_ready = 1'b1;
        exp_lat.push_back(cyc + (nresp ? TMO + 1 : rsdly + 2));
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (!nresp) begin
          repeat (rsdly) @(negedge clk);
          mem_resp_valid = 1'b1;
          mem_rdata      = mem_fn(a);
          @(negedge clk);
          mem_resp_valid = 1'b0;
          mem_rdata      = $urandom;
        end
      end
    end
  end

  // Memory-side monitor: fields match the predicted request on every REQ cycle
  req_t cur;
  logic prev_mrv = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_mrv = 1'b0;
    else begin
      if (mem_req_valid && !prev_mrv) begin
        if (exp_req.size() == 0) fail_now("unexpected_mem_req");
        else cur = exp_req.pop_front();
      end
      if (mem_req_valid) begin
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wen", mem_wen, cur.wen);
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("mem_wmask", mem_wmask, cur.wmask);
      end
      prev_mrv = mem_req_valid;
    end
  end

  // Response monitor: owner, data, arrival cycle, rdata hold and sticky bus_err
  resp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (ifu_resp_valid || lsu_resp_valid) begin
        if (exp_resp.size() == 0) fail_now("unexpected_resp");
        else begin
          e = exp_resp.pop_front();
          chk("ifu_resp_valid", ifu_resp_valid, !e.lsu);
          chk("lsu_resp_valid", lsu_resp_valid, e.lsu);
          chk("mem_req_valid_idle", mem_req_valid, 0);
          if (e.lsu) exp_lsu_rd = e.rdata; else exp_ifu_rd = e.rdata;
          if (e.tmo) exp_bus_err = 1'b1;
          if (exp_lat.size() == 0) fail_now("resp_without_handshake");
          else chk("resp_cycle", cyc, exp_lat.pop_front());
        end
      end
      chk("ifu_rdata", ifu_rdata, exp_ifu_rd);
      chk("lsu_rdata", lsu_rdata, exp_lsu_rd);
      chk("bus_err", bus_err, exp_bus_err);
    end
  end

  // Fixed-priority instance observation
  int p_ifu_gnt = 0, p_lsu_gnt = 0, p_ifu_rsp = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (p_ifu_req_ready) p_ifu_gnt++;
      if (p_lsu_req_ready) p_lsu_gnt++;
      if (p_ifu_resp_valid) p_ifu_rsp++;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_ifu_req_ready", ifu_req_ready, 0);
    chk("rst_lsu_req_ready", lsu_req_ready, 0);
    chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
    chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
    chk("rst_ifu_rdata", ifu_rdata, 0);
    chk("rst_lsu_rdata", lsu_rdata, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_bus_err", bus_err, 0);
  endtask

  // Issue one arbitration round; the model predicts the winner and the full transaction outcome
  task automatic issue(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                       input bit wen, input logic [31:0] wd, input logic [3:0] wm,
                       input int rd, input int rs, input bit nr, input bit wait_done);
    bit    w;
    req_t  r;
    resp_t x;
    int    n;
    @(posedge clk); #1;
    rdly = rd; rsdly = rs; nresp = nr;
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    w = (iv && lv) ? !last_lsu : lv;
    @(negedge clk);
    chk("ifu_req_ready", ifu_req_ready, !w);
    chk("lsu_req_ready", lsu_req_ready, w);
    r.addr  = w ? la : ia;
    r.wen   = w & wen;
    r.wdata = w ? wd : 32'h0;
    r.wmask = w ? wm : 4'h0;
    x.lsu   = w;
    x.rdata = nr ? 32'h0 : mem_fn(r.addr);
    x.tmo   = nr;
    exp_req.push_back(r);
    exp_resp.push_back(x);
    last_lsu = w;
    // Junk requests after the grant must be neither accepted nor leak into mem_*
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = $urandom; lsu_addr = $urandom; lsu_wen = 1'($urandom);
    lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
    @(negedge clk);
    chk("mem_req_valid_c1", mem_req_valid, 1);
    chk("busy_ifu_req_ready", ifu_req_ready, 0);
    chk("busy_lsu_req_ready", lsu_req_ready, 0);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (exp_resp.size() != 0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (exp_resp.size() != 0) begin
        fail_now("resp_never_arrived");
        exp_resp.delete(); exp_req.delete(); exp_lat.delete();
      end
    end
  endtask

  initial begin
    bit iv, lv;
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Lone IFU fetch
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 1'b1);
    // LSU store with memory stalling the handshake for 4 cycles
    issue(1'b0, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'hCAFE_BABE, 4'hF, 4, 1, 1'b0, 1'b1);
    // Round-robin with both requesting
    for (int i = 0; i < 4; i++)
      issue(1'b1, 1'b1, 32'h8000_0100 + 32'(i * 4), 32'h8000_2000 + 32'(i * 4),
            1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 1'b1);
    // Timeout on an LSU load
    issue(1'b0, 1'b1, 32'h0, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 0, 0, 1'b1, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 24; i++) begin
      iv = 1'($urandom);
      lv = 1'($urandom);
      if (!iv && !lv) iv = 1'b1;
      issue(iv, lv, $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0, 1'b1);
    end

    // Reset in the middle of RESP, then a stray memory response
    issue(1'b1, 1'b0, 32'h8000_4000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_resp.delete(); exp_req.delete(); exp_lat.delete();
    last_lsu = 1'b1; exp_bus_err = 1'b0; exp_ifu_rd = 32'h0; exp_lsu_rd = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    issue(1'b1, 1'b0, 32'h8000_5000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    chk("leftover_mem_reqs", exp_req.size(), 0);
    chk("prio_ifu_grants", p_ifu_gnt, 0);
    chk("prio_ifu_resps", p_ifu_rsp, 0);
    chk("prio_lsu_grants_ge4", (p_lsu_gnt >= 4), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
